seq_loop_monitor: RTL and testbench

SEQ_LOOP_MONITOR -- requirements
Module: seq_loop_monitor

---
 rtl/seq_loop_monitor.sv | 158 +++++++++++++++
 tb/tb_seq_loop_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_loop_monitor.sv
// Watches an FSM state stream and checks loop entry, iteration and exit behaviour.
// Optional watchdog: define SEQ_LOOP_MON_TIMEOUT_EN to build the per-iteration timeout.
module seq_loop_monitor #(
    parameter int FSM_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [FSM_WIDTH-1:0]    cur_state,
    input  logic                    pre_states_valid,
    input  logic [FSM_WIDTH-1:0]    pre_loop_state0,
    input  logic                    post_states_valid,
    input  logic [FSM_WIDTH-1:0]    post_loop_state0,
    input  logic [15:0]             quit_states_valid,
    input  logic [16*FSM_WIDTH-1:0] quit_loop_states,
    input  logic [FSM_WIDTH-1:0]    loop_quit_state,
    input  logic [FSM_WIDTH-1:0]    iter_start_state,
    input  logic [FSM_WIDTH-1:0]    iter_end_state0,
    input  logic                    iter_end_states_valid,
    input  logic                    one_state_loop,
    input  logic                    one_state_block,
    input  logic                    finish,
    output logic                    loop_active,
    output logic                    loop_done,
    output logic [31:0]             iter_count,
    output logic [15:0]             loop_count,
    output logic                    err_bad_exit,
    output logic                    err_bad_iter,
    output logic                    err_unterminated,
    output logic                    err_timeout
);

    typedef enum logic [1:0] {IDLE, PRE, IN_LOOP, DONE} mon_state_t;

    mon_state_t           state;
    logic [FSM_WIDTH-1:0] prev_state;
    logic                 end_seen;
    logic                 quit_hit;
    logic                 at_start;
    logic                 iter_start;
    logic                 at_exit;
    logic                 at_pre;
    logic                 bad_iter;

    // NOTE: assign a default before the loop so no path leaves quit_hit unassigned (no latch).
    always_comb begin
        quit_hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (quit_states_valid[i] && prev_state == quit_loop_states[i*FSM_WIDTH +: FSM_WIDTH])
                quit_hit = 1'b1;
        end
    end

    assign at_start   = (cur_state == iter_start_state);
    assign iter_start = at_start && (one_state_loop || prev_state != iter_start_state);
    assign at_exit    = (cur_state == loop_quit_state);
    assign at_pre     = pre_states_valid && (cur_state == pre_loop_state0);
    assign bad_iter   = !end_seen && iter_end_states_valid && !one_state_loop && !one_state_block;

    // NOTE: sequential state uses non-blocking assignments only; every register, including
    // the counters, is cleared by the async reset since software reads them directly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            prev_state       <= '0;
            end_seen         <= 1'b0;
            loop_active      <= 1'b0;
            loop_done        <= 1'b0;
            iter_count       <= '0;
            loop_count       <= '0;
            err_bad_exit     <= 1'b0;
            err_bad_iter     <= 1'b0;
            err_unterminated <= 1'b0;
        end else begin
            prev_state <= cur_state;
            loop_done  <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    // The cycle after an exit must show the expected post-loop state.
                    if (state == DONE && post_states_valid && cur_state != post_loop_state0)
                        err_bad_exit <= 1'b1;
                    if (at_pre) begin
                        state       <= PRE;
                        loop_active <= 1'b0;
                    end else if (at_start) begin
                        state       <= IN_LOOP;
                        loop_active <= 1'b1;
                        iter_count  <= 32'd1;
                        end_seen    <= 1'b0;
                    end else begin
                        state       <= IDLE;
                        loop_active <= 1'b0;
                    end
                end
                PRE: begin
                    if (finish) begin
                        state            <= IDLE;
                        err_unterminated <= 1'b1;
                    end else if (at_start) begin
                        state       <= IN_LOOP;
                        loop_active <= 1'b1;
                        iter_count  <= 32'd1;
                        end_seen    <= 1'b0;
                    end else if (cur_state != pre_loop_state0) begin
                        state <= IDLE;
                    end
                end
                IN_LOOP: begin
                    if (finish) begin
                        state            <= IDLE;
                        loop_active      <= 1'b0;
                        err_unterminated <= 1'b1;
                    end else if (at_exit) begin
                        // Exit outranks a coincident iteration start.
                        state       <= DONE;
                        loop_active <= 1'b0;
                        loop_done   <= 1'b1;
                        if (quit_hit)
                            loop_count <= loop_count + 16'd1;
                        else
                            err_bad_exit <= 1'b1;
                    end else if (iter_start) begin
                        if (iter_count != '1)
                            iter_count <= iter_count + 32'd1;
                        end_seen <= 1'b0;
                        if (bad_iter)
                            err_bad_iter <= 1'b1;
                    end else if (iter_end_states_valid && cur_state == iter_end_state0) begin
                        end_seen <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_LOOP_MON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cycles;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            err_timeout  <= 1'b0;
        end else if (state != IN_LOOP || finish || at_exit || iter_start) begin
            stall_cycles <= '0;
        end else begin
            if (int'(stall_cycles) < TIMEOUT_CYCLES)
                stall_cycles <= stall_cycles + 1'b1;
            if (int'(stall_cycles) + 1 >= TIMEOUT_CYCLES)
                err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seq_loop_monitor.sv
// Directed bench for seq_loop_monitor: expected outputs are queued per step and checked after each edge.
module tb_seq_loop_monitor;

`ifdef SEQ_LOOP_MON_TIMEOUT_EN
    localparam int TO = 8;
    localparam logic TO_EN = 1'b1;
`else
    localparam int TO = 1024;
    localparam logic TO_EN = 1'b0;
`endif
    localparam int W = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  cur_state = '0;
    logic          pre_states_valid = 1'b1;
    logic [W-1:0]  pre_loop_state0 = 3'd1;
    logic          post_states_valid = 1'b0;
    logic [W-1:0]  post_loop_state0 = 3'd5;
    logic [15:0]   quit_states_valid = 16'h0001;
    logic [16*W-1:0] quit_loop_states = {45'd0, 3'd3};
    logic [W-1:0]  loop_quit_state = 3'd4;
    logic [W-1:0]  iter_start_state = 3'd2;
    logic [W-1:0]  iter_end_state0 = 3'd3;
    logic          iter_end_states_valid = 1'b1;
    logic          one_state_loop = 1'b0;
    logic          one_state_block = 1'b0;
    logic          finish = 1'b0;
    logic          loop_active, loop_done;
    logic [31:0]   iter_count;
    logic [15:0]   loop_count;
    logic          err_bad_exit, err_bad_iter, err_unterminated, err_timeout;

    typedef struct {
        string       tag;
        logic        act;
        logic        done;
        logic [31:0] it;
        logic [15:0] lc;
        logic [3:0]  err;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    seq_loop_monitor #(.FSM_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .pre_states_valid(pre_states_valid), .pre_loop_state0(pre_loop_state0),
        .post_states_valid(post_states_valid), .post_loop_state0(post_loop_state0),
        .quit_states_valid(quit_states_valid), .quit_loop_states(quit_loop_states),
        .loop_quit_state(loop_quit_state), .iter_start_state(iter_start_state),
        .iter_end_state0(iter_end_state0), .iter_end_states_valid(iter_end_states_valid),
        .one_state_loop(one_state_loop), .one_state_block(one_state_block), .finish(finish),
        .loop_active(loop_active), .loop_done(loop_done), .iter_count(iter_count),
        .loop_count(loop_count), .err_bad_exit(err_bad_exit), .err_bad_iter(err_bad_iter),
        .err_unterminated(err_unterminated), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".active"}, 32'(loop_active), 32'(e.act));
        chk({e.tag, ".done"}, 32'(loop_done), 32'(e.done));
        chk({e.tag, ".iter"}, iter_count, e.it);
        chk({e.tag, ".loops"}, 32'(loop_count), 32'(e.lc));
        chk({e.tag, ".errs"}, 32'({err_bad_exit, err_bad_iter, err_unterminated, err_timeout}),
            32'(e.err));
    endtask

    // err order: {bad_exit, bad_iter, unterminated, timeout}
    task automatic step(input string tag, input logic [W-1:0] cs, input logic act, input logic done,
                        input logic [31:0] it, input logic [15:0] lc, input logic [3:0] err);
        exp_t e;
        cur_state = cs;
        e.tag = tag; e.act = act; e.done = done; e.it = it; e.lc = lc; e.err = err;
        sb.push_back(e);
        @(posedge clock);
        #1;
        compare_front();
    endtask

    task automatic do_reset(input string tag);
        cur_state = '0;
        reset = 1'b0;
        #1;
        sb.push_back('{tag, 1'b0, 1'b0, 32'd0, 16'd0, 4'd0});
        compare_front();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        sb.push_back('{"reset_state", 1'b0, 1'b0, 32'd0, 16'd0, 4'd0});
        compare_front();
        #11;
        reset = 1'b1;

        // Nominal loop through the pre-loop state, three iterations, clean exit.
        step("a_pre",  3'd1, 0, 0, 0, 0, 4'b0000);
        step("a_in",   3'd2, 1, 0, 1, 0, 4'b0000);
        step("a_e1",   3'd3, 1, 0, 1, 0, 4'b0000);
        step("a_s2",   3'd2, 1, 0, 2, 0, 4'b0000);
        step("a_e2",   3'd3, 1, 0, 2, 0, 4'b0000);
        step("a_s3",   3'd2, 1, 0, 3, 0, 4'b0000);
        step("a_e3",   3'd3, 1, 0, 3, 0, 4'b0000);
        step("a_exit", 3'd4, 0, 1, 3, 1, 4'b0000);
        step("a_idle", 3'd0, 0, 0, 3, 1, 4'b0000);

        // Exit from a state that is not a quit state.
        step("b_in",   3'd2, 1, 0, 1, 1, 4'b0000);
        step("b_hold", 3'd2, 1, 0, 1, 1, 4'b0000);
        step("b_exit", 3'd4, 0, 1, 1, 1, 4'b1000);
        step("b_idle", 3'd0, 0, 0, 1, 1, 4'b1000);

        // Iteration restart without passing the end state.
        do_reset("c_rst");
        step("c_in",   3'd2, 1, 0, 1, 0, 4'b0000);
        step("c_mid",  3'd5, 1, 0, 1, 0, 4'b0000);
        step("c_s2",   3'd2, 1, 0, 2, 0, 4'b0100);
        step("c_e",    3'd3, 1, 0, 2, 0, 4'b0100);
        step("c_exit", 3'd4, 0, 1, 2, 1, 4'b0100);
        step("c_idle", 3'd0, 0, 0, 2, 1, 4'b0100);

        do_reset("d_rst");
        one_state_block = 1'b1;
        step("d_in",   3'd2, 1, 0, 1, 0, 4'b0000);
        step("d_mid",  3'd5, 1, 0, 1, 0, 4'b0000);
        step("d_s2",   3'd2, 1, 0, 2, 0, 4'b0000);
        step("d_e",    3'd3, 1, 0, 2, 0, 4'b0000);
        step("d_exit", 3'd4, 0, 1, 2, 1, 4'b0000);
        one_state_block = 1'b0;

        // Single-state loop: every cycle in the start state is an iteration.
        do_reset("o_rst");
        one_state_loop = 1'b1;
        step("o_in",   3'd2, 1, 0, 1, 0, 4'b0000);
        step("o_s2",   3'd2, 1, 0, 2, 0, 4'b0000);
        step("o_s3",   3'd2, 1, 0, 3, 0, 4'b0000);
        step("o_e",    3'd3, 1, 0, 3, 0, 4'b0000);
        step("o_exit", 3'd4, 0, 1, 3, 1, 4'b0000);
        one_state_loop = 1'b0;

        // finish while looping abandons the loop.
        do_reset("f_rst");
        step("f_in",   3'd2, 1, 0, 1, 0, 4'b0000);
        step("f_e1",   3'd3, 1, 0, 1, 0, 4'b0000);
        step("f_s2",   3'd2, 1, 0, 2, 0, 4'b0000);
        step("f_e2",   3'd3, 1, 0, 2, 0, 4'b0000);
        finish = 1'b1;
        step("f_fin",  3'd3, 0, 0, 2, 0, 4'b0010);
        step("f_idle", 3'd3, 0, 0, 2, 0, 4'b0010);
        finish = 1'b0;

        // Post-state mismatch together with back-to-back loop entry.
        do_reset("p_rst");
        post_states_valid = 1'b1;
        step("p_in",    3'd2, 1, 0, 1, 0, 4'b0000);
        step("p_e",     3'd3, 1, 0, 1, 0, 4'b0000);
        step("p_exit",  3'd4, 0, 1, 1, 1, 4'b0000);
        step("p_b2b",   3'd2, 1, 0, 1, 1, 4'b1000);
        step("p_e2",    3'd3, 1, 0, 1, 1, 4'b1000);
        step("p_exit2", 3'd4, 0, 1, 1, 2, 4'b1000);
        step("p_post",  3'd5, 0, 0, 1, 2, 4'b1000);
        post_states_valid = 1'b0;

        // Reset in the middle of an iteration discards the loop.
        step("r_in",   3'd2, 1, 0, 1, 2, 4'b1000);
        step("r_e",    3'd3, 1, 0, 1, 2, 4'b1000);
        do_reset("r_rst");
        step("r_quit", 3'd4, 0, 0, 0, 0, 4'b0000);

        // Stall inside an iteration; the watchdog fires only when built in.
        step("t_in",   3'd2, 1, 0, 1, 0, 4'b0000);
        for (int i = 0; i < 7; i++)
            step("t_hold", 3'd3, 1, 0, 1, 0, 4'b0000);
        step("t_to",   3'd3, 1, 0, 1, 0, {3'b000, TO_EN});
        step("t_stay", 3'd3, 1, 0, 1, 0, {3'b000, TO_EN});
        step("t_exit", 3'd4, 0, 1, 1, 1, {3'b000, TO_EN});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
